// File: rtl/conv_acc_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// conv_acc_pkg : shared widths and the channel-sum adder for the accumulator.
// Macro CONV_ACC_SAT_EN selects saturating adds (default: wrap).  Rev 1.0
// -----------------------------------------------------------------------------
package conv_acc_pkg;

  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  function automatic int pxl_cnt_w(input int image_size);
    return $clog2(image_size);
  endfunction

  function automatic int ch_cnt_w(input int ch_num);
    return $clog2(ch_num) + 1;
  endfunction

  // Operands arrive sign-extended to 64 bits from a field whose sign bit is msb,
  // so the 65-bit raw sum is exact and bit msb+1 holds the true sign.
  function automatic sat_res_t sat_add(input logic [63:0] a, input logic [63:0] b,
                                       input logic [6:0] msb);
    logic [64:0] raw;
    logic [63:0] max_v;
    sat_res_t    r;
    raw   = {a[63], a} + {b[63], b};
    max_v = (64'd1 << msb) - 64'd1;
    r.ovf = raw[msb + 7'd1] ^ raw[msb];
    r.sum = raw[63:0];
`ifdef CONV_ACC_SAT_EN
    if (r.ovf) begin
      r.sum = raw[msb + 7'd1] ? ~max_v : max_v;
    end
`endif
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_acc_psum_ram.sv
`default_nettype none
// -----------------------------------------------------------------------------
// conv_acc_psum_ram : simple dual-port partial-sum store, registered read.
// Rev 1.0
// -----------------------------------------------------------------------------
module conv_acc_psum_ram
  import conv_acc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 17,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // No reset: contents are masked by the first-channel select upstream.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/conv_channel_accumulator.sv
`default_nettype none
// -----------------------------------------------------------------------------
// conv_channel_accumulator : sums CHANNEL_NUM_IN planes per pixel, one plane out.
// Macro CONV_ACC_SAT_EN selects saturating adds (default: wrap).  Rev 1.0
// -----------------------------------------------------------------------------
module conv_channel_accumulator
  import conv_acc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int IMAGE_SIZE     = 256*256,
  parameter int CHANNEL_NUM_IN = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  ovf,
  output logic                  frame_done
);

  localparam int PXL_CNT_W = pxl_cnt_w(IMAGE_SIZE);
  localparam int CH_CNT_W  = ch_cnt_w(CHANNEL_NUM_IN);
  localparam int RAM_W     = DATA_WIDTH + 1;
  localparam logic [PXL_CNT_W-1:0] PXL_LAST = PXL_CNT_W'(IMAGE_SIZE - 1);
  localparam logic [CH_CNT_W-1:0]  CH_LAST  = CH_CNT_W'(CHANNEL_NUM_IN - 1);

  if (IMAGE_SIZE < 4) begin : g_chk_image_size
    $error("IMAGE_SIZE must be at least 4");
  end
  if (CHANNEL_NUM_IN < 1) begin : g_chk_ch_num
    $error("CHANNEL_NUM_IN must be at least 1");
  end
  if (DATA_WIDTH >= SAT_MAX_W) begin : g_chk_data_width
    $error("DATA_WIDTH must be below 64");
  end

  logic en;
  logic accept;

  logic [PXL_CNT_W-1:0] pxl_cnt_q, pxl_cnt_d;
  logic [CH_CNT_W-1:0]  ch_cnt_q, ch_cnt_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [PXL_CNT_W-1:0]  s1_addr_q, s1_addr_d;
  logic                  s1_first_q, s1_first_d;
  logic                  s1_last_q, s1_last_d;
  logic                  s1_eof_q, s1_eof_d;

  logic                  valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
  logic                  ovf_q, ovf_d;
  logic                  eof_q, eof_d;

  logic                  wr_en;
  logic [RAM_W-1:0]      wr_data;
  logic [RAM_W-1:0]      rd_data;

  logic [DATA_WIDTH-1:0] op_b;
  logic                  op_b_ovf;
  sat_res_t              add_res;
  logic [DATA_WIDTH-1:0] sum;
  logic                  sum_ovf;
  logic                  sum_hi_unused;

  assign en       = !valid_out_q || ready_out;
  assign ready_in = en;
  assign accept   = valid_in && en;

  always_comb begin
    pxl_cnt_d = pxl_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    if (accept) begin
      if (pxl_cnt_q == PXL_LAST) begin
        pxl_cnt_d = '0;
        ch_cnt_d  = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + 1'b1;
      end else begin
        pxl_cnt_d = pxl_cnt_q + 1'b1;
      end
    end
  end

  // S0 -> S1: the buffer read is issued on the same enable, so its data lines up.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_addr_d  = s1_addr_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_eof_d   = s1_eof_q;
    if (en) begin
      s1_valid_d = accept;
      s1_data_d  = pxl_in;
      s1_addr_d  = pxl_cnt_q;
      s1_first_d = (ch_cnt_q == '0);
      s1_last_d  = (ch_cnt_q == CH_LAST);
      s1_eof_d   = (ch_cnt_q == CH_LAST) && (pxl_cnt_q == PXL_LAST);
    end
  end

  conv_acc_psum_ram #(
    .DEPTH  (IMAGE_SIZE),
    .WIDTH  (RAM_W),
    .ADDR_W (PXL_CNT_W)
  ) u_psum_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (s1_addr_q),
    .wr_data (wr_data),
    .rd_en   (en),
    .rd_addr (pxl_cnt_q),
    .rd_data (rd_data)
  );

  // Channel 0 ignores stale buffer contents, which is why the RAM needs no reset.
  always_comb begin
    op_b          = s1_first_q ? '0 : rd_data[DATA_WIDTH-1:0];
    op_b_ovf      = !s1_first_q && rd_data[DATA_WIDTH];
    add_res       = sat_add(64'($signed(s1_data_q)), 64'($signed(op_b)),
                            7'(DATA_WIDTH - 1));
    sum           = add_res.sum[DATA_WIDTH-1:0];
    sum_ovf       = op_b_ovf | add_res.ovf;
    sum_hi_unused = ^add_res.sum[SAT_MAX_W-1:DATA_WIDTH];
  end

  assign wr_en   = en && s1_valid_q && !s1_last_q;
  assign wr_data = {sum_ovf, sum};

  always_comb begin
    valid_out_d = valid_out_q;
    pxl_out_d   = pxl_out_q;
    ovf_d       = ovf_q;
    eof_d       = eof_q;
    if (en) begin
      valid_out_d = s1_valid_q && s1_last_q;
      if (s1_valid_q && s1_last_q) begin
        pxl_out_d = sum;
        ovf_d     = sum_ovf;
        eof_d     = s1_eof_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_addr_q   <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_eof_q    <= 1'b0;
      valid_out_q <= 1'b0;
      pxl_out_q   <= '0;
      ovf_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      pxl_cnt_q   <= pxl_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_addr_q   <= s1_addr_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_eof_q    <= s1_eof_d;
      valid_out_q <= valid_out_d;
      pxl_out_q   <= pxl_out_d;
      ovf_q       <= ovf_d;
      eof_q       <= eof_d;
    end
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = valid_out_q;
  assign ovf        = ovf_q;
  assign frame_done = valid_out_q && ready_out && eof_q;

endmodule
`default_nettype wire
